// File: rtl/phase_detector_filter.sv
// ADPLL front end: reference synchroniser, signed ref/fb phase detector and a
// random-walk loop filter that trims the DCO period, plus lock detection.
module phase_detector_filter #(
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned K_TH     = 4,
  parameter int unsigned DEADBAND = 1,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           ref_in,
  input  logic           fb_in,
  output logic           ref_rise,
  output logic           add_pulse,
  output logic           sub_pulse,
  output logic [ERR_W:0] phase_err,
  output logic           locked
);

  localparam int unsigned PW = ERR_W + 1;
  localparam int unsigned KW = 5;
  localparam int unsigned LW = 8;

  localparam logic [ERR_W-1:0]     ERR_MAX   = '1;
  localparam logic signed [PW-1:0] ERR_MAX_S = PW'(ERR_MAX);
  localparam logic signed [PW-1:0] DB_POS    = PW'(DEADBAND);
  localparam logic signed [PW-1:0] DB_NEG    = -DB_POS;
  localparam logic signed [KW-1:0] K_MAX     = KW'(K_TH - 1);
  localparam logic signed [KW-1:0] K_MIN     = -K_MAX;
  localparam logic [LW-1:0]        LOCK_MAX  = LW'(LOCK_CNT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_FB  = 2'd1;
  localparam logic [1:0] S_WAIT_REF = 2'd2;

  logic                 s1_q, s2_q, s2d_q, fb_d_q;
  logic                 ref_ev_c, fb_ev_c;
  logic [1:0]           state_q, state_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic signed [PW-1:0] cnt_s_c, err_c;
  logic                 close_c, up_c, dn_c;
  logic signed [KW-1:0] k_cnt_q, k_cnt_d;
  logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                 locked_q, locked_d;
  logic                 add_q, add_d, sub_q, sub_d;
  logic                 ref_rise_q;
  logic [PW-1:0]        perr_q, perr_d;

  assign ref_ev_c = s2_q & ~s2d_q;
  assign fb_ev_c  = fb_in & ~fb_d_q;
  assign cnt_s_c  = $signed({1'b0, err_cnt_q});
  assign up_c     = close_c && (err_c > DB_POS);
  assign dn_c     = close_c && (err_c < DB_NEG);

  // Edge-ordering FSM: decides when a measurement closes and with what error.
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    close_c   = 1'b0;
    err_c     = '0;
    if (!en) begin
      state_d   = S_IDLE;
      err_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ref_ev_c && fb_ev_c) begin
            close_c = 1'b1;
          end else if (ref_ev_c) begin
            state_d   = S_WAIT_FB;
            err_cnt_d = ERR_W'(1);
          end else if (fb_ev_c) begin
            state_d   = S_WAIT_REF;
            err_cnt_d = ERR_W'(1);
          end
        end
        S_WAIT_FB: begin
          if (fb_ev_c) begin
            close_c = 1'b1;
            err_c   = cnt_s_c;
            if (ref_ev_c) err_cnt_d = ERR_W'(1);
            else          state_d   = S_IDLE;
          end else if (ref_ev_c) begin
            close_c   = 1'b1;
            err_c     = ERR_MAX_S;
            err_cnt_d = ERR_W'(1);
          end else if (err_cnt_q == ERR_MAX) begin
            close_c = 1'b1;
            err_c   = ERR_MAX_S;
            state_d = S_IDLE;
          end else begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        S_WAIT_REF: begin
          if (ref_ev_c) begin
            close_c = 1'b1;
            err_c   = -cnt_s_c;
            if (fb_ev_c) err_cnt_d = ERR_W'(1);
            else         state_d   = S_IDLE;
          end else if (fb_ev_c) begin
            close_c   = 1'b1;
            err_c     = -ERR_MAX_S;
            err_cnt_d = ERR_W'(1);
          end else if (err_cnt_q == ERR_MAX) begin
            close_c = 1'b1;
            err_c   = -ERR_MAX_S;
            state_d = S_IDLE;
          end else begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Random-walk filter and lock tracking, advanced once per closed measurement.
  always_comb begin
    k_cnt_d    = k_cnt_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    add_d      = 1'b0;
    sub_d      = 1'b0;
    perr_d     = perr_q;
    if (!en) begin
      k_cnt_d    = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (close_c) begin
      perr_d = err_c;
      if (up_c) begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        if (k_cnt_q == K_MAX) begin
          sub_d   = 1'b1;
          k_cnt_d = '0;
        end else begin
          k_cnt_d = k_cnt_q + KW'(1);
        end
      end else if (dn_c) begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        if (k_cnt_q == K_MIN) begin
          add_d   = 1'b1;
          k_cnt_d = '0;
        end else begin
          k_cnt_d = k_cnt_q - KW'(1);
        end
      end else begin
        if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
        if (lock_cnt_d == LOCK_MAX) locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s2d_q      <= 1'b0;
      fb_d_q     <= 1'b0;
      ref_rise_q <= 1'b0;
      state_q    <= S_IDLE;
      err_cnt_q  <= '0;
      k_cnt_q    <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      add_q      <= 1'b0;
      sub_q      <= 1'b0;
      perr_q     <= '0;
    end else begin
      s1_q       <= ref_in;
      s2_q       <= s1_q;
      s2d_q      <= s2_q;
      fb_d_q     <= fb_in;
      ref_rise_q <= ref_ev_c;
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      k_cnt_q    <= k_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      add_q      <= add_d;
      sub_q      <= sub_d;
      perr_q     <= perr_d;
    end
  end

  assign ref_rise  = ref_rise_q;
  assign add_pulse = add_q;
  assign sub_pulse = sub_q;
  assign phase_err = perr_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_phase_detector_filter.sv
// Bench for phase_detector_filter: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model.
module tb_phase_detector_filter;

  localparam int ERR_W    = 8;
  localparam int K_TH     = 4;
  localparam int DEADBAND = 1;
  localparam int LOCK_CNT = 8;
  localparam int ERR_MAX  = 255;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           ref_in;
  logic           fb_in;
  logic           ref_rise;
  logic           add_pulse;
  logic           sub_pulse;
  logic [ERR_W:0] phase_err;
  logic           locked;

  int checks   = 0;
  int failures = 0;
  int n_add    = 0;
  int n_sub    = 0;
  int n_both   = 0;

  phase_detector_filter #(
    .ERR_W(ERR_W), .K_TH(K_TH), .DEADBAND(DEADBAND), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .ref_rise(ref_rise), .add_pulse(add_pulse), .sub_pulse(sub_pulse),
    .phase_err(phase_err), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges are timestamped; error is the timestamp difference.
  int       m_t = 0;
  int       m_t0 = 0;
  int       m_pend = 0;
  int       m_k = 0;
  int       m_lc = 0;
  int       m_perr = 0;
  int       m_err = 0;
  bit [2:0] m_rh = '0;
  bit       m_fbp = 1'b0;
  bit       m_rise = 1'b0;
  bit       m_add = 1'b0;
  bit       m_sub = 1'b0;
  bit       m_locked = 1'b0;
  bit       m_rev, m_fev, m_close;

  always @(posedge clk) begin
    m_rev   = m_rh[1] && !m_rh[2];
    m_fev   = fb_in && !m_fbp;
    m_close = 1'b0;
    m_err   = 0;
    m_add   = 1'b0;
    m_sub   = 1'b0;
    if (!rst_n) begin
      m_rh = '0; m_fbp = 1'b0; m_rise = 1'b0; m_pend = 0;
      m_k = 0; m_lc = 0; m_locked = 1'b0; m_perr = 0;
    end else begin
      m_rise = m_rev;
      m_rh   = {m_rh[1:0], ref_in};
      m_fbp  = fb_in;
      if (!en) begin
        m_pend = 0; m_k = 0; m_lc = 0; m_locked = 1'b0;
      end else begin
        if (m_pend == 0) begin
          if (m_rev && m_fev) m_close = 1'b1;
          else if (m_rev) begin m_pend = 1; m_t0 = m_t; end
          else if (m_fev) begin m_pend = -1; m_t0 = m_t; end
        end else begin
          bit own, other;
          own   = (m_pend > 0) ? m_fev : m_rev;
          other = (m_pend > 0) ? m_rev : m_fev;
          if (own) begin
            m_close = 1'b1; m_err = m_pend * (m_t - m_t0);
            if (other) m_t0 = m_t; else m_pend = 0;
          end else if (other) begin
            m_close = 1'b1; m_err = m_pend * ERR_MAX; m_t0 = m_t;
          end else if (m_t - m_t0 == ERR_MAX) begin
            m_close = 1'b1; m_err = m_pend * ERR_MAX; m_pend = 0;
          end
        end
        if (m_close) begin
          m_perr = m_err;
          if (m_err > DEADBAND) begin
            m_lc = 0; m_locked = 1'b0;
            if (m_k == K_TH - 1) begin m_sub = 1'b1; m_k = 0; end else m_k++;
          end else if (m_err < -DEADBAND) begin
            m_lc = 0; m_locked = 1'b0;
            if (m_k == -(K_TH - 1)) begin m_add = 1'b1; m_k = 0; end else m_k--;
          end else begin
            m_lc = (m_lc + 1 > LOCK_CNT) ? LOCK_CNT : m_lc + 1;
            if (m_lc == LOCK_CNT) m_locked = 1'b1;
          end
        end
      end
    end
    m_t++;
  end

  // ref_ev lands at window edge r (r<2 means none); fb_ev at edge f (f<0 none).
  task automatic run_pair(input int r, input int f, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (add_pulse) n_add++;
      if (sub_pulse) n_sub++;
      if (add_pulse && sub_pulse) n_both++;
      ref_in = (r >= 2) && (c >= r - 2) && (c < r + 2);
      fb_in  = (f >= 0) && (c >= f) && (c < f + 4);
    end
    @(negedge clk);
    if (add_pulse) n_add++;
    if (sub_pulse) n_sub++;
    if (add_pulse && sub_pulse) n_both++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ref_rise !== 1'b0) begin failures++; $display("FAIL reset_ref_rise got=%b exp=0", ref_rise); end
    checks++; if (add_pulse !== 1'b0 || sub_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", add_pulse, sub_pulse); end
    checks++; if (phase_err !== '0) begin failures++; $display("FAIL reset_phase_err got=%0d exp=0", phase_err); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst_n = 1'b1; en = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if ({ref_rise, add_pulse, sub_pulse, locked} !== 4'b0 || phase_err !== '0) begin
      failures++; $display("FAIL idle_outputs got=%b%b%b%b/%0d exp=0000/0", ref_rise, add_pulse, sub_pulse, locked, phase_err);
    end
  endtask

  task automatic test_ref_rise();
    int seen = 0;
    // ref_in first sampled high at edge E0 -> pulse visible after E2 only.
    @(negedge clk); ref_in = 1'b1;
    @(negedge clk);
    if (ref_rise) seen++;
    @(negedge clk);
    if (ref_rise) seen++;
    @(negedge clk);
    checks++; if (ref_rise !== 1'b1 || seen != 0) begin failures++; $display("FAIL ref_rise_latency got=%b early=%0d exp=1/0", ref_rise, seen); end
    ref_in = 1'b0;
    @(negedge clk);
    checks++; if (ref_rise !== 1'b0) begin failures++; $display("FAIL ref_rise_width got=%b exp=0", ref_rise); end
    // the lone ref edge opened a measurement; let en clear it
    en = 1'b0; @(negedge clk); en = 1'b1; @(negedge clk);
  endtask

  task automatic test_fb_lag();
    n_add = 0; n_sub = 0;
    for (int i = 0; i < 4; i++) begin
      run_pair(2, 7, 13);
      checks++; if (phase_err !== 9'd5) begin failures++; $display("FAIL lag_phase_err[%0d] got=%0d exp=5", i, $signed(phase_err)); end
      if (i == 2) begin
        checks++; if (n_sub != 0) begin failures++; $display("FAIL lag_early_sub got=%0d exp=0", n_sub); end
      end
    end
    checks++; if (n_sub != 1 || n_add != 0) begin failures++; $display("FAIL lag_pulses got sub=%0d add=%0d exp sub=1 add=0", n_sub, n_add); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lag_locked got=%b exp=0", locked); end
  endtask

  task automatic test_fb_lead();
    n_add = 0; n_sub = 0;
    for (int i = 0; i < 4; i++) begin
      run_pair(5, 2, 9);
      checks++; if (phase_err !== 9'h1FD) begin failures++; $display("FAIL lead_phase_err[%0d] got=%0d exp=-3", i, $signed(phase_err)); end
    end
    checks++; if (n_add != 1 || n_sub != 0) begin failures++; $display("FAIL lead_pulses got add=%0d sub=%0d exp add=1 sub=0", n_add, n_sub); end
  endtask

  task automatic test_lock();
    n_add = 0; n_sub = 0;
    for (int i = 0; i < 8; i++) begin
      run_pair(2, 2, 8);
      if (i == 6) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", locked); end
      end
    end
    checks++; if (locked !== 1'b1 || phase_err !== '0) begin failures++; $display("FAIL lock_after8 got=%b/%0d exp=1/0", locked, phase_err); end
    for (int i = 0; i < 8; i++) run_pair(2, 3, 9);
    checks++; if (locked !== 1'b1 || phase_err !== 9'd1) begin failures++; $display("FAIL lock_inband got=%b/%0d exp=1/1", locked, phase_err); end
    run_pair(2, 7, 13);
    checks++; if (locked !== 1'b0 || phase_err !== 9'd5) begin failures++; $display("FAIL lock_lost got=%b/%0d exp=0/5", locked, phase_err); end
    checks++; if (n_add != 0 || n_sub != 0) begin failures++; $display("FAIL lock_pulses got add=%0d sub=%0d exp 0/0", n_add, n_sub); end
  endtask

  task automatic test_timeout();
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    n_add = 0; n_sub = 0;
    run_pair(2, -1, 262);
    checks++; if (phase_err !== 9'd255) begin failures++; $display("FAIL timeout_phase_err got=%0d exp=255", $signed(phase_err)); end
    checks++; if (n_sub != 0 || n_add != 0) begin failures++; $display("FAIL timeout_pulses got sub=%0d add=%0d exp 0/0", n_sub, n_add); end
    run_pair(2, 7, 13);
    checks++; if (phase_err !== 9'd5 || n_sub != 0) begin failures++; $display("FAIL timeout_idle got=%0d sub=%0d exp=5/0", $signed(phase_err), n_sub); end
    run_pair(2, 7, 13);
    checks++; if (n_sub != 0) begin failures++; $display("FAIL timeout_k_early got=%0d exp=0", n_sub); end
    run_pair(2, 7, 13);
    checks++; if (n_sub != 1) begin failures++; $display("FAIL timeout_k_one got=%0d exp=1", n_sub); end
  endtask

  task automatic test_slip();
    n_add = 0; n_sub = 0;
    run_pair(2, -1, 39);
    run_pair(2, -1, 4);
    checks++; if (phase_err !== 9'd255) begin failures++; $display("FAIL slip_phase_err got=%0d exp=255", $signed(phase_err)); end
    run_pair(0, 5, 11);
    checks++; if (phase_err !== 9'd8) begin failures++; $display("FAIL slip_stays_wait_fb got=%0d exp=8", $signed(phase_err)); end
    checks++; if (n_add != 0 || n_sub != 0) begin failures++; $display("FAIL slip_pulses got add=%0d sub=%0d exp 0/0", n_add, n_sub); end
  endtask

  task automatic test_reset_mid();
    run_pair(2, -1, 12);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({ref_rise, add_pulse, sub_pulse, locked} !== 4'b0 || phase_err !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%b%b%b%b/%0d exp=0000/0", ref_rise, add_pulse, sub_pulse, locked, phase_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (add_pulse !== 1'b0 || sub_pulse !== 1'b0) begin failures++; $display("FAIL midreset_next got=%b%b exp=00", add_pulse, sub_pulse); end
    run_pair(2, 4, 10);
    checks++; if (phase_err !== 9'd2) begin failures++; $display("FAIL midreset_idle got=%0d exp=2", $signed(phase_err)); end
  endtask

  task automatic test_en_drop();
    n_add = 0; n_sub = 0;
    run_pair(2, 7, 13);
    run_pair(2, 7, 13);
    checks++; if (n_sub != 0) begin failures++; $display("FAIL endrop_pre got=%0d exp=0", n_sub); end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    checks++; if (add_pulse !== 1'b0 || sub_pulse !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL endrop_outputs got=%b%b%b exp=000", add_pulse, sub_pulse, locked); end
    checks++; if (phase_err !== 9'd5) begin failures++; $display("FAIL endrop_hold got=%0d exp=5", $signed(phase_err)); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) run_pair(2, 7, 13);
    checks++; if (n_sub != 0) begin failures++; $display("FAIL endrop_k_cleared got=%0d exp=0", n_sub); end
    run_pair(2, 7, 13);
    checks++; if (n_sub != 1) begin failures++; $display("FAIL endrop_k_resume got=%0d exp=1", n_sub); end
  endtask

  task automatic test_random(input int ncyc);
    int       mode = 0;
    int       seg = 0;
    int       d = 2;
    logic [7:0] hist = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      checks++; if (ref_rise !== m_rise) begin failures++; $display("FAIL rnd_ref_rise cyc=%0d got=%b exp=%b", c, ref_rise, m_rise); end
      checks++; if (add_pulse !== m_add) begin failures++; $display("FAIL rnd_add cyc=%0d got=%b exp=%b", c, add_pulse, m_add); end
      checks++; if (sub_pulse !== m_sub) begin failures++; $display("FAIL rnd_sub cyc=%0d got=%b exp=%b", c, sub_pulse, m_sub); end
      checks++; if (phase_err !== 9'(m_perr)) begin failures++; $display("FAIL rnd_phase_err cyc=%0d got=%0d exp=%0d", c, $signed(phase_err), m_perr); end
      checks++; if (locked !== m_locked) begin failures++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", c, locked, m_locked); end
      if (seg == 0) begin
        mode = $urandom_range(0, 3);
        seg  = $urandom_range(150, 400);
        d    = $urandom_range(0, 6);
      end
      seg--;
      case (mode)
        0: begin
          if ($urandom_range(0, 5) == 0) ref_in = ~ref_in;
          if ($urandom_range(0, 4) == 0) fb_in = ~fb_in;
        end
        1, 2: begin
          if ($urandom_range(0, 5) == 0) ref_in = ~ref_in;
          fb_in = hist[d];
        end
        default: begin
          if ($urandom_range(0, 149) == 0) ref_in = ~ref_in;
          fb_in = 1'b0;
        end
      endcase
      hist  = {hist[6:0], ref_in};
      en    = ($urandom_range(0, 199) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    rst_n = 1'b1; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ref_rise();
    test_fb_lag();
    test_fb_lead();
    test_lock();
    test_timeout();
    test_slip();
    test_reset_mid();
    test_en_drop();
    test_random(4000);
    checks++; if (n_both != 0) begin failures++; $display("FAIL pulses_together got=%0d exp=0", n_both); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
